// File: rtl/mem_boot_arbiter.sv
// Boot sequencer and data-memory arbiter between the pipeline data port and an external loader.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_boot_arbiter #(
  parameter int unsigned MIN_BOOT_CYCLES = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_wr,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [1:0]  p_size,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  output logic        pc_sel,
  input  logic        l_req,
  input  logic        l_wr,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  input  logic [1:0]  l_size,
  input  logic        l_done,
  output logic        l_gnt,
  output logic [31:0] l_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wr,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_lgnt_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] MIN_BOOT   = 8'(MIN_BOOT_CYCLES);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] bootCnt;
  logic [7:0] starveCnt;

  logic lGnt;
  logic pGnt;
  logic stall;
  logic pcSel;
  logic forceLoader;

  assign forceLoader = (starveCnt == STARVE_MAX) && l_req;

  // Grants are gated by rst_n so an access presented in the reset cycle never reaches memory.
  always_comb begin
    lGnt  = 1'b0;
    pGnt  = 1'b0;
    stall = 1'b1;
    pcSel = 1'b1;
    if (rst_n) begin
      case (state)
        BOOT: begin
          lGnt  = l_req;
          stall = 1'b1;
          pcSel = 1'b1;
        end
        START: begin
          lGnt  = l_req;
          stall = 1'b0;
          pcSel = 1'b1;
        end
        RUN: begin
          pcSel = 1'b0;
          stall = 1'b0;
          if (forceLoader) begin
            lGnt  = 1'b1;
            stall = p_req;
          end else if (p_req) begin
            pGnt = 1'b1;
          end else if (l_req) begin
            lGnt = 1'b1;
          end
        end
        default: begin
          lGnt  = 1'b0;
          pGnt  = 1'b0;
          stall = 1'b1;
          pcSel = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wr    = 1'b0;
    m_size  = '0;
    if (lGnt) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_wr    = l_wr & l_req;
      m_size  = l_size;
    end else if (pGnt) begin
      m_addr  = p_addr;
      m_wdata = p_wdata;
      m_wr    = p_wr & p_req;
      m_size  = p_size;
    end
  end

  assign l_gnt   = lGnt;
  assign l_rdata = lGnt ? m_rdata : '0;
  assign p_rdata = pGnt ? m_rdata : '0;
  assign p_stall = stall;
  assign pc_sel  = pcSel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      bootCnt   <= '0;
      starveCnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (bootCnt != MIN_BOOT) bootCnt <= bootCnt + 8'd1;
          if (l_done && (bootCnt == MIN_BOOT)) state <= START;
        end
        START: begin
          state     <= RUN;
          starveCnt <= '0;
        end
        RUN: begin
          if (l_req && !lGnt) begin
            if (starveCnt != STARVE_MAX) starveCnt <= starveCnt + 8'd1;
          end else begin
            starveCnt <= '0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stallCnt;
  logic [15:0] lgntCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= '0;
      lgntCnt  <= '0;
    end else begin
      if ((state == RUN) && stall && (stallCnt != '1)) stallCnt <= stallCnt + 16'd1;
      if (lGnt && (lgntCnt != '1)) lgntCnt <= lgntCnt + 16'd1;
    end
  end

  assign perf_stall_cnt = stallCnt;
  assign perf_lgnt_cnt  = lgntCnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_lgnt_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Directed scoreboard bench for mem_boot_arbiter with a word-addressed data memory model.
module tb_mem_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_wr, l_req, l_wr, l_done;
  logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
  logic [1:0]  p_size, l_size;
  logic [31:0] p_rdata, l_rdata, m_addr, m_wdata, m_rdata;
  logic        p_stall, pc_sel, l_gnt, m_wr;
  logic [1:0]  m_size;
  logic [15:0] perf_stall_cnt, perf_lgnt_cnt;

  mem_boot_arbiter #(.MIN_BOOT_CYCLES(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_size(p_size),
    .p_rdata(p_rdata), .p_stall(p_stall), .pc_sel(pc_sel),
    .l_req(l_req), .l_wr(l_wr), .l_addr(l_addr), .l_wdata(l_wdata), .l_size(l_size),
    .l_done(l_done), .l_gnt(l_gnt), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_size(m_size), .m_rdata(m_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_lgnt_cnt(perf_lgnt_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) if (m_wr) mem[m_addr[9:2]] <= m_wdata;
  assign m_rdata = mem[m_addr[9:2]];

  typedef enum int {PCSEL, PSTALL, LGNT, MWR, MADDR, MWDATA, MSIZE,
                    LRDATA, PRDATA, STALLCNT, LGNTCNT} sig_t;
  typedef struct { sig_t id; logic [31:0] v; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] obs(sig_t id);
    case (id)
      PCSEL:    return {31'd0, pc_sel};
      PSTALL:   return {31'd0, p_stall};
      LGNT:     return {31'd0, l_gnt};
      MWR:      return {31'd0, m_wr};
      MADDR:    return m_addr;
      MWDATA:   return m_wdata;
      MSIZE:    return {30'd0, m_size};
      LRDATA:   return l_rdata;
      PRDATA:   return p_rdata;
      STALLCNT: return {16'd0, perf_stall_cnt};
      default:  return {16'd0, perf_lgnt_cnt};
    endcase
  endfunction

  task automatic expect_(sig_t id, logic [31:0] v);
    exp_t e;
    e.id = id;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    logic [31:0] o;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.id);
      total++;
      assert (o === e.v) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", e.id.name(), o, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic dn);
    p_req = pr; p_wr = pw; p_addr = pa; p_wdata = pd; p_size = 2'b10;
    l_req = lr; l_wr = lw; l_addr = la; l_wdata = ld; l_size = 2'b10; l_done = dn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] expStall, expLgnt;
`ifdef ARB_PERF_CNT_EN
    expStall = 16'd3;
    expLgnt  = 16'd6;
`else
    expStall = 16'd0;
    expLgnt  = 16'd0;
`endif
    // Reset: a loader write presented during reset must be blocked.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h10, 32'h5555_5555, 1'b1, 1'b1, 32'h10, 32'h6666_6666, 1'b0);
      expect_(PCSEL, 1); expect_(PSTALL, 1); expect_(LGNT, 0); expect_(MWR, 0);
      expect_(MADDR, 0); expect_(MWDATA, 0); expect_(MSIZE, 0); expect_(PRDATA, 0);
      cycle();
    end
    rst_n = 1'b1;

    // BOOT c0: loader write wins over a simultaneous pipeline request.
    drive(1'b1, 1'b1, 32'h40, 32'h1111_1111, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    expect_(LGNT, 1); expect_(MWR, 1); expect_(MADDR, 32'h10); expect_(MWDATA, 32'hDEAD_BEEF);
    expect_(MSIZE, 2); expect_(PSTALL, 1); expect_(PCSEL, 1); expect_(PRDATA, 0);
    cycle();
    // BOOT c1: loader read-back, l_done raised.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    expect_(LGNT, 1); expect_(MWR, 0); expect_(LRDATA, 32'hDEAD_BEEF); expect_(PRDATA, 0);
    expect_(PSTALL, 1); expect_(PCSEL, 1);
    cycle();
    // BOOT c2..c4: l_done held but minimum boot time not yet reached.
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      expect_(PCSEL, 1); expect_(PSTALL, 1); expect_(LGNT, 0); expect_(MWR, 0); expect_(MADDR, 0);
      cycle();
    end
    // START.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    expect_(PCSEL, 1); expect_(PSTALL, 0); expect_(LGNT, 1); expect_(LRDATA, 32'hDEAD_BEEF);
    expect_(PRDATA, 0); expect_(MADDR, 32'h10);
    cycle();

    // RUN priority: 8 pipeline grants then one forced loader grant, repeating.
    for (int r = 0; r < 27; r++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
      expect_(PCSEL, 0);
      if ((r % 9) == 8) begin
        expect_(LGNT, 1); expect_(PSTALL, 1); expect_(MADDR, 32'h44); expect_(PRDATA, 0);
      end else begin
        expect_(LGNT, 0); expect_(PSTALL, 0); expect_(MADDR, 32'h10);
        expect_(PRDATA, 32'hDEAD_BEEF); expect_(LRDATA, 0);
      end
      cycle();
    end

    // Loader alone: granted every cycle, counters observed after the priority run.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      expect_(LGNT, 1); expect_(PSTALL, 0); expect_(LRDATA, 32'hDEAD_BEEF);
      if (i == 0) begin
        expect_(STALLCNT, {16'd0, expStall}); expect_(LGNTCNT, {16'd0, expLgnt});
      end
      cycle();
    end
    // Starvation counter stayed clear: full 8 pipeline grants before the forced one.
    for (int r = 0; r < 9; r++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
      expect_(LGNT, (r == 8) ? 32'd1 : 32'd0);
      expect_(PSTALL, (r == 8) ? 32'd1 : 32'd0);
      cycle();
    end

    // Idle.
    drive(1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h84, 32'hFFFF_FFFF, 1'b0);
    expect_(MWR, 0); expect_(MADDR, 0); expect_(LGNT, 0); expect_(PSTALL, 0); expect_(PRDATA, 0);
    cycle();

    // Pipeline write, then reset asserted during a second write to the same word.
    drive(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_(MWR, 1); expect_(MADDR, 32'h20); expect_(MWDATA, 32'h1234_5678); expect_(PSTALL, 0);
    cycle();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h20, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_(MWR, 0); expect_(MADDR, 0); expect_(PCSEL, 1); expect_(PSTALL, 1);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    expect_(PCSEL, 1); expect_(PSTALL, 1); expect_(LGNT, 1); expect_(LRDATA, 32'h1234_5678);
    expect_(STALLCNT, 0); expect_(LGNTCNT, 0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
